key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Classifies debounced key activity into one-cycle event pulses: short press, double click, long press and, optionally, auto-repeat while held. It sits directly downstream of the key debouncer and consumes its active-low debounced level `click_n`. Its pulses feed the menu and control logic, so no downstream block needs to time key presses itself. One instance is used per key.

## Interface
- `LONG_TIME`, 50_000_000: cycles the key must be held for a long press (1 s at 50 MHz).
- `DBL_GAP`, 12_500_000: maximum release-to-press gap, in cycles, for a double click (250 ms).
- `REPEAT_TIME`, 5_000_000: auto-repeat interval in cycles (100 ms).
- `CNT_W`, 26: counter width. Must satisfy 2^CNT_W > max(`LONG_TIME`, `DBL_GAP`, `REPEAT_TIME`).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `click_n`  in  1  debounced key level; 0 = pressed. It is already synchronous to `clk`.
- `short_p`  out  1  one-cycle pulse for a single short press.
- `double_p`  out  1  one-cycle pulse for a double click.
- `long_p`  out  1  one-cycle pulse when the long-press threshold is reached.
- `repeat_p`  out  1  one-cycle auto-repeat pulse while the key is held after a long press.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Edge detection:
  - `click_d` registers `click_n`; its reset value is 1.
  - fall = `click_d` & ~`click_n`; rise = ~`click_d` & `click_n`.
- A single counter `cnt` (width `CNT_W`) is cleared on every state change.
- States and transitions:
  - IDLE: on fall, go to PRESS1.
  - PRESS1: if rise, go to WAIT2. Else if `cnt` == `LONG_TIME`-1, assert `long_p` and go to HOLD. Else `cnt`++.
  - WAIT2: if fall, assert `double_p` and go to PRESS2. Else if `cnt` == `DBL_GAP`-1, assert `short_p` and go to IDLE. Else `cnt`++.
  - PRESS2: wait for rise, then go to IDLE. A long hold in this state produces no `long_p` and no repeats.
  - HOLD: if rise, go to IDLE. Else if `cnt` == `REPEAT_TIME`-1, assert `repeat_p` (macro-dependent) and clear `cnt`. Else `cnt`++.
- Simultaneous events:
  - In PRESS1, a rise in the same cycle as the threshold wins: no `long_p`, go to WAIT2.
  - In WAIT2, a fall in the same cycle as the timeout wins: `double_p`, no `short_p`.
- Exclusivity: at most one of the four pulse outputs is high in any cycle. Each key gesture yields exactly one of `short_p`, `double_p`, `long_p`.
- Reset:
  - Asserting `rst_n` at any time forces IDLE, `cnt` = 0, `click_d` = 1, and all outputs to 0 immediately. An event in progress is discarded.
  - If the key is still low when reset releases, the first clock detects a fall and a fresh PRESS1 begins.
- Unused state encodings recover to IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Let E be the clock edge at which fall or rise is detected (`click_d` still holds the old level).
- Long press: `long_p` is high for the cycle after edge E+`LONG_TIME`-1, counting from the fall at edge E.
- First `repeat_p` follows `long_p` by `REPEAT_TIME` cycles; later pulses are spaced every `REPEAT_TIME` cycles.
- Short press: `short_p` is high `DBL_GAP` cycles after the release edge E.
- Double click: `double_p` is high the cycle after the second fall is detected.
- `busy` tracks the state register with no extra latency.
- Pulse width is exactly 1 cycle.

## Configuration
- `KEY_EVENT_REPEAT_EN`:
  - Defined: HOLD generates `repeat_p` as specified.
  - Undefined: the repeat counter logic is not compiled, `repeat_p` is tied to 0, and HOLD only waits for rise.
  - All other behaviour is identical in both builds.

## Test plan
Bench parameters: `LONG_TIME`=20, `DBL_GAP`=10, `REPEAT_TIME`=5.
- Hold low 5 cycles, release, stay high 30 cycles -> one `short_p` 10 cycles after the rise is detected; `double_p`, `long_p`, `repeat_p` stay 0; `busy` falls with `short_p`.
- Low 5, high 4, low 5, high -> one `double_p` the cycle after the second fall; no `short_p`.
- Hold low 38 cycles with the macro defined -> `long_p` 20 cycles after the fall; `repeat_p` at 25, 30, 35; nothing after release. Same stimulus without the macro -> `long_p` only.
- Release exactly at `cnt`=19 in PRESS1 -> no `long_p`; `short_p` 10 cycles later.
- Second press arriving at `cnt`=9 in WAIT2 -> `double_p`, no `short_p`.
- Assert `rst_n` mid-HOLD with the key held low -> all outputs and `busy` go to 0 asynchronously. After release of reset, `busy`=1 from the next edge, and `long_p` fires 20 cycles later if the key is still held.

Source files
------------

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: bundles the debounced key level going into the decoder
// with the event pulses and busy flag coming out of it.
`timescale 1ns/1ps
interface key_event_decoder_if;
  logic click_n;   // debounced key level, 0 = pressed
  logic short_p;   // single short press
  logic double_p;  // double click
  logic long_p;    // long-press threshold reached
  logic repeat_p;  // auto-repeat tick while held after a long press
  logic busy;      // decoder is tracking a gesture

  // Key side / consumer of events
  modport master (
    output click_n,
    input  short_p, double_p, long_p, repeat_p, busy
  );

  // Decoder side
  modport slave (
    input  click_n,
    output short_p, double_p, long_p, repeat_p, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns the debounced, active-low key level into one-cycle
// event pulses (short press, double click, long press, auto-repeat).
// A single counter times every phase and is cleared on each state change.
// Optional feature macro: KEY_EVENT_REPEAT_EN. When defined, HOLD emits
// repeat_p every REPEAT_TIME cycles; when undefined, the repeat timer is not
// built, repeat_p is tied low and HOLD only waits for the key release.
`timescale 1ns/1ps
module key_event_decoder #(
  parameter int LONG_TIME   = 50_000_000,
  parameter int DBL_GAP     = 12_500_000,
  parameter int REPEAT_TIME = 5_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  key_event_decoder_if.slave  bus
);

  // The counter must reach every terminal count without wrapping.
  localparam longint MAX_TIME =
    (LONG_TIME >= DBL_GAP && LONG_TIME >= REPEAT_TIME) ? longint'(LONG_TIME) :
    (DBL_GAP >= REPEAT_TIME)                           ? longint'(DBL_GAP)   :
                                                         longint'(REPEAT_TIME);

  generate
    if ((longint'(1) << CNT_W) <= MAX_TIME) begin : g_cnt_w_too_small
      $error("key_event_decoder: CNT_W too small for the configured timings");
    end
  endgenerate

  // Terminal counts: the event fires on the cycle the counter shows N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TIME - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             click_q;          // previous key level, idles released
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
`ifdef KEY_EVENT_REPEAT_EN
  logic             repeat_q, repeat_d;
`endif

  logic fall;
  logic rise;

  // Key edges against the previous level; a key held low through reset
  // release is seen as a fresh press because click_q resets high.
  assign fall = click_q & ~bus.click_n;
  assign rise = ~click_q & bus.click_n;

  // State register, counter, edge history and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      click_q  <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      click_q  <= bus.click_n;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_q <= repeat_d;
`endif
    end
  end

  // Gesture classification: next state, counter update and pulse requests.
  // Key edges are tested before the terminal counts so that an edge landing
  // on the same cycle as a timeout takes precedence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = PRESS1;
        end
      end

      PRESS1: begin
        if (rise) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end
      end

      WAIT2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      // Second press of a double click: its duration is irrelevant.
      PRESS2: begin
        cnt_d = '0;
        if (rise) begin
          state_d = IDLE;
        end
      end

      HOLD: begin
`ifdef KEY_EVENT_REPEAT_EN
        if (rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`else
        cnt_d = '0;
        if (rise) begin
          state_d = IDLE;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.short_p  = short_q;
  assign bus.double_p = double_q;
  assign bus.long_p   = long_q;
`ifdef KEY_EVENT_REPEAT_EN
  assign bus.repeat_p = repeat_q;
`else
  assign bus.repeat_p = 1'b0;
`endif
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: scenario tasks drive key gestures and push the
// expected pulses (kind and cycle) into a scoreboard; a negedge monitor pops
// and compares every pulse the decoder emits.
`timescale 1ns/1ps
module tb_key_event_decoder;
  localparam int LT = 20;
  localparam int DG = 10;
  localparam int RT = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_event_decoder_if bus();

  key_event_decoder #(
    .LONG_TIME  (LT),
    .DBL_GAP    (DG),
    .REPEAT_TIME(RT),
    .CNT_W      (26)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef enum int {EV_SHORT = 0, EV_DOUBLE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_t;
  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] ev_vec(ev_t k);
    case (k)
      EV_SHORT:  return 4'b1000;
      EV_DOUBLE: return 4'b0100;
      EV_LONG:   return 4'b0010;
      default:   return 4'b0001;
    endcase
  endfunction

  logic [3:0] mon_v;
  exp_t       mon_e;

  // Scoreboard monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_v = {bus.short_p, bus.double_p, bus.long_p, bus.repeat_p};
      if (mon_v !== 4'b0000) begin
        n_checks++;
        if ($countones(mon_v) != 1) begin
          n_fail++;
          $display("FAIL exclusive_pulses: got %b at cycle %0d, required one-hot", mon_v, cyc);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got %b at cycle %0d, required no pulse", mon_v, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_v !== ev_vec(mon_e.kind) || cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL pulse_match: got %b at cycle %0d, required %b at cycle %0d",
                     mon_v, cyc, ev_vec(mon_e.kind), mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input ev_t k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Wait (bounded) for all expected pulses, then idle to expose strays.
  task automatic wait_drain(output int left);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 80) begin
      step(1);
      t++;
    end
    left = sb.size();
    sb.delete();
    step(15);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.click_n = 1'b1;
    step(2);
    n_checks++;
    if ({bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy});
    end
    rst_n = 1'b1;
    step(3);
    n_checks++;
    if ({bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, required 00000",
               {bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy});
    end
  endtask

  task automatic test_short();
    int n, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    step(5);
    bus.click_n = 1'b1;             // rise at n+6
    expect_ev(EV_SHORT, n + 16);
    step(10);                       // cycle n+15
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL short_busy_before: got %b, required 1", bus.busy);
    end
    step(1);                        // cycle n+16
    n_checks++;
    if (bus.busy !== 1'b0 || bus.short_p !== 1'b1) begin
      n_fail++;
      $display("FAIL short_busy_with_pulse: got busy=%b short=%b, required busy=0 short=1",
               bus.busy, bus.short_p);
    end
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL short_missing: got %0d pulses outstanding, required 0", left);
    end
  endtask

  task automatic test_double();
    int n, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    step(5);
    bus.click_n = 1'b1;             // rise at n+6
    step(4);
    bus.click_n = 1'b0;             // fall at n+10
    expect_ev(EV_DOUBLE, n + 10);
    step(5);
    bus.click_n = 1'b1;
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL double_missing: got %0d pulses outstanding, required 0", left);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL double_busy_after: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_long();
    int n, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    expect_ev(EV_LONG, n + 21);
`ifdef KEY_EVENT_REPEAT_EN
    expect_ev(EV_REPEAT, n + 26);
    expect_ev(EV_REPEAT, n + 31);
    expect_ev(EV_REPEAT, n + 36);
`endif
    step(38);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL long_busy_held: got %b, required 1", bus.busy);
    end
    bus.click_n = 1'b1;             // rise at n+39
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL long_missing: got %0d pulses outstanding, required 0", left);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL long_busy_after: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_release_at_threshold();
    int n, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    step(20);
    bus.click_n = 1'b1;             // rise at n+21, same cycle as cnt=19
    expect_ev(EV_SHORT, n + 31);
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL threshold_release_missing: got %0d pulses outstanding, required 0", left);
    end
  endtask

  task automatic test_double_at_timeout();
    int n, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    step(5);
    bus.click_n = 1'b1;             // rise at n+6
    step(10);
    bus.click_n = 1'b0;             // fall at n+16, same cycle as cnt=9
    expect_ev(EV_DOUBLE, n + 16);
    step(5);
    bus.click_n = 1'b1;
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL timeout_double_missing: got %0d pulses outstanding, required 0", left);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n, m, left;
    n = cyc;
    bus.click_n = 1'b0;             // fall at n+1
    expect_ev(EV_LONG, n + 21);
    step(23);                       // in HOLD
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required 00000",
               {bus.short_p, bus.double_p, bus.long_p, bus.repeat_p, bus.busy});
    end
    step(3);
    rst_n = 1'b1;
    m = cyc;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_release: got %b, required 0", bus.busy);
    end
    expect_ev(EV_LONG, m + 21);
    step(1);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_release: got %b, required 1", bus.busy);
    end
    step(21);
    bus.click_n = 1'b1;
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL reset_long_missing: got %0d pulses outstanding, required 0", left);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long();
    test_release_at_threshold();
    test_double_at_timeout();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
